mod_pre_scale: RTL
==================

# mod_pre_scale

Iterative modular pre-scaler for the NTT datapath. It computes C = (A · 2^K) mod q with one conditional-subtract doubling per cycle. This is the inverse of the 2^-K scaling that the word-level product reduction stage applies, where K = L_SIZE·(W_SIZE−1). The block sits upstream of the butterfly array. It converts twiddle factors and input coefficients into the scaled domain, so that products leaving the reduction stage come out in plain residue form.

## Interface
- DATA_W, 32: coefficient and modulus width; matches the datapath word size.
- K, 48: scaling exponent, 1..255; set to L_SIZE·(W_SIZE−1) at instantiation.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept an operand pair.
- A  in  DATA_W  operand, required < q.
- q  in  DATA_W  odd modulus, 3 ≤ q < 2^DATA_W.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- C  out  DATA_W  (A·2^K) mod q.
- range_err  out  1  A ≥ q was captured; C is not meaningful.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch q into q_r and A into x, set range_err_r = (A ≥ q), load cnt = K, go to RUN.
- RUN, every cycle:
  - t = {x, 1'b0} (DATA_W+1 bits).
  - d = t − q_r, computed DATA_W+2 bits wide, sign in the MSB.
  - x ← d negative ? t[DATA_W-1:0] : d[DATA_W-1:0].
  - cnt ← cnt − 1.
  - When cnt reaches 1 and that step completes, go to DONE.
- DONE: out_valid = 1; C = x; range_err = range_err_r. On out_ready, go to IDLE.
- Invariant: x < q_r holds throughout RUN, so a single subtraction per step is sufficient.
- If A ≥ q, the arithmetic proceeds unchanged and flags range_err. The cycle count is identical and C is don't-care.
- q and A are sampled only on the accept edge. Changes on those inputs while not in IDLE have no effect.
- K is a compile-time parameter. cnt is 8 bits wide.

## Timing
- Reset values:
  - State IDLE.
  - in_ready = 1.
  - out_valid = 0, C = 0, range_err = 0.
  - x = 0, q_r = 0, cnt = 0.
- Accept cycle: in_valid & in_ready at edge n.
- out_valid rises at edge n+K, so latency is K cycles after accept.
- C, range_err and out_valid are register-driven and glitch-free.
- Backpressure: while out_valid & !out_ready, C and range_err hold stable and in_ready stays 0.
- Result transfer happens at an edge with out_valid & out_ready. At that edge the state moves to IDLE and out_valid drops.
- in_ready is high from the following cycle. The minimum initiation interval is K+2 cycles, with no same-cycle result/accept overlap.
- in_ready is 0 in RUN and DONE. in_valid asserted there is ignored, and the operand is not captured.
- Reset mid-RUN or mid-DONE:
  - Immediate return to IDLE.
  - out_valid drops asynchronously.
  - The in-flight result is discarded; no partial result is ever presented.
- K = 1 boundary: out_valid rises at edge n+1.
- Single in-flight operation; no internal buffering beyond the result register.

## Test plan
- DATA_W=16, K=4; A=1, q=7 -> C=2, range_err=0. out_valid is exactly 4 cycles after accept.
- DATA_W=16, K=16; A=1, q=12289 -> C=4091. A=12288, q=12289 -> C=8198. Check against a reference model of (A·2^K) mod q over 10k random (A<q, odd q) pairs.
- DATA_W=32, K=1; A=4294967290, q=4294967291 -> C=4294967289. This exercises the DATA_W+1-bit doubling overflow path.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. C stays constant, in_ready stays 0, and an in_valid pulse during this window is not captured. Then out_ready=1 for one cycle -> out_valid drops next edge and in_ready returns.
- Range error: A=9, q=7, K=4 -> range_err=1 with out_valid at the nominal latency. The next operation with A=3 returns range_err=0 and C=6 (48 mod 7).
- Reset asserted 2 cycles into RUN -> out_valid=0, in_ready=1 immediately after reset release. A fresh operation A=1, q=7, K=4 -> C=2 with full latency, and no stale result appears.

Source files
------------

// File: rtl/mod_pre_scale_if.sv
// mod_pre_scale_if: operand/result handshake bundle for the modular pre-scaler
interface mod_pre_scale_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] C;
  logic              range_err;
  modport master (output in_valid, A, q, out_ready, input in_ready, out_valid, C, range_err);
  modport slave  (input in_valid, A, q, out_ready, output in_ready, out_valid, C, range_err);
endinterface

// File: rtl/mod_pre_scale.sv
// mod_pre_scale: iterative C = (A * 2^K) mod q, one conditional-subtract doubling per cycle
module mod_pre_scale #(
  parameter int DATA_W = 32,
  parameter int K      = 48
) (
  input logic          clk,
  input logic          reset,
  mod_pre_scale_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [DATA_W-1:0] x, q_r, x_nxt;
  logic [7:0]        cnt;
  logic              range_err_r, in_ready_r, out_valid_r;
  logic [DATA_W:0]   t;
  logic [DATA_W+1:0] d;
  // x < q_r keeps 2x < 2q_r, so one subtraction brings the double back into range
  always_comb begin
    t     = {x, 1'b0};
    d     = {1'b0, t} - {2'b00, q_r};
    x_nxt = d[DATA_W+1] ? t[DATA_W-1:0] : d[DATA_W-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      range_err_r <= 1'b0;
      x           <= '0;
      q_r         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          q_r         <= bus.q;
          x           <= bus.A;
          range_err_r <= bus.A >= bus.q;
          cnt         <= 8'(K);
          in_ready_r  <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          x   <= x_nxt;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.C         = x;
  assign bus.range_err = range_err_r;
endmodule
